vr_stream_checker: RTL and testbench

- Consumer end of the team's valid/ready stream interface.
- Attaches to the down side of any FIFO/custom-logic pipeline and drives the ready signal with a programmable, LFSR-based throttle to create backpressure.
- Checks that accepted beats form a contiguous incrementing sequence (mod 2^D_WIDTH).
- Counts accepted beats and sequence errors for bring-up and regression.

---
 rtl/vr_stream_pkg.sv | 16 +
 rtl/vr_lfsr16.sv | 27 ++
 rtl/vr_stream_checker.sv | 110 +++++++++++
 tb/tb_vr_stream_checker.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vr_stream_pkg.sv
// vr_stream_pkg
//   Shared definitions for the valid/ready stream checker and its matching
//   stream source: FSM state encoding and the 16-bit throttle LFSR constants.
package vr_stream_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    RUN
  } state_t;

  // Galois feedback mask for taps 16,14,13,11 (maximal length).
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

endpackage

// File: rtl/vr_lfsr16.sv
// vr_lfsr16
//   16-bit Galois LFSR used to throttle stream handshakes.
//   Ports:
//     clk      rising-edge clock
//     rst      asynchronous active-high reset, loads SEED
//     advance  step the LFSR by one position this cycle
//     state    current LFSR contents
module vr_lfsr16
  import vr_stream_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        advance,
  output logic [15:0] state
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEED;
    end else if (advance) begin
      state <= {1'b0, state[15:1]} ^ (state[0] ? LFSR_TAPS : '0);
    end
  end

endmodule

// File: rtl/vr_stream_checker.sv
// vr_stream_checker
//   Consumer end of a valid/ready stream. Drives a throttled, registered
//   up_ready and checks that accepted beats form a contiguous incrementing
//   sequence modulo 2^D_WIDTH.
//   Ports:
//     clk, rst   rising-edge clock, asynchronous active-high reset
//     en         enable; low forces up_ready low and the FSM to IDLE
//     clr        synchronous clear of beat_cnt, err_cnt and err_flag
//     throttle   backpressure level; 0 means always ready when enabled
//     up_data    stream data
//     up_valid   stream valid
//     up_ready   stream ready (registered, independent of up_valid)
//     beat_cnt   accepted beats, saturating
//     err_cnt    sequence mismatches, saturating
//     err_flag   sticky mismatch flag
//     expected   next expected data value
module vr_stream_checker
  import vr_stream_pkg::*;
#(
  parameter int unsigned D_WIDTH   = 6,
  parameter int unsigned CNT_WIDTH = 16,
  parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 clr,
  input  logic [3:0]           throttle,
  input  logic [D_WIDTH-1:0]   up_data,
  input  logic                 up_valid,
  output logic                 up_ready,
  output logic [CNT_WIDTH-1:0] beat_cnt,
  output logic [CNT_WIDTH-1:0] err_cnt,
  output logic                 err_flag,
  output logic [D_WIDTH-1:0]   expected
);

  logic [15:0] lfsr;
  // Only the low nibble sets the throttle; the rest feeds the recurrence.
  logic [11:0] lfsr_unused;
  state_t      state;
  logic        accept;
  logic        match;
  logic        checked;

  assign lfsr_unused = lfsr[15:4];

  vr_lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .advance (en),
    .state   (lfsr)
  );

  assign accept  = up_valid && up_ready;
  assign match   = (up_data == expected);
  assign checked = (state == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      up_ready <= 1'b0;
      beat_cnt <= '0;
      err_cnt  <= '0;
      err_flag <= 1'b0;
      expected <= '0;
    end else begin
      // IDLE holds ready low for one edge, so the first beat always lands in SYNC.
      up_ready <= en && (state != IDLE) && (lfsr[3:0] >= throttle);

      if (accept) begin
        if (checked && match) begin
          expected <= expected + D_WIDTH'(1);
        end else begin
          expected <= up_data + D_WIDTH'(1);
        end
        if (beat_cnt != '1) begin
          beat_cnt <= beat_cnt + CNT_WIDTH'(1);
        end
        if (checked && !match) begin
          err_flag <= 1'b1;
          if (err_cnt != '1) begin
            err_cnt <= err_cnt + CNT_WIDTH'(1);
          end
        end
      end

      // clr overrides the counters and flag but not the expected update.
      if (clr) begin
        beat_cnt <= '0;
        err_cnt  <= '0;
        err_flag <= 1'b0;
      end

      if (!en) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE:    state <= SYNC;
          SYNC:    if (accept) state <= RUN;
          RUN:     state <= RUN;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vr_stream_checker.sv
// tb_vr_stream_checker
//   Self-checking bench for vr_stream_checker: a cycle model predicts
//   up_ready every cycle and pushes the expected counter/expected state for
//   each accepted beat into a scoreboard that is compared one half-cycle later.
module tb_vr_stream_checker;

  localparam int unsigned DW = 6;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          clr;
  logic [3:0]    throttle;
  logic [DW-1:0] up_data;
  logic          up_valid;
  logic          up_ready;
  logic [CW-1:0] beat_cnt;
  logic [CW-1:0] err_cnt;
  logic          err_flag;
  logic [DW-1:0] expected;

  always #5 clk = ~clk;

  vr_stream_checker #(
    .D_WIDTH   (DW),
    .CNT_WIDTH (CW),
    .LFSR_SEED (16'hACE1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .clr      (clr),
    .throttle (throttle),
    .up_data  (up_data),
    .up_valid (up_valid),
    .up_ready (up_ready),
    .beat_cnt (beat_cnt),
    .err_cnt  (err_cnt),
    .err_flag (err_flag),
    .expected (expected)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum logic [1:0] {M_IDLE, M_SYNC, M_RUN} mstate_t;

  typedef struct packed {
    logic [DW-1:0] exp;
    logic [CW-1:0] beat;
    logic [CW-1:0] err;
    logic          flag;
  } res_t;

  mstate_t       m_state;
  logic [15:0]   m_lfsr;
  logic          m_ready;
  logic [DW-1:0] m_exp,  n_exp;
  logic [CW-1:0] m_beat, n_beat;
  logic [CW-1:0] m_err,  n_err;
  logic          m_flag, n_flag;
  logic          m_acc;
  res_t          sb[$];
  res_t          sb_item;

  always_comb begin
    m_acc  = up_valid && m_ready;
    n_exp  = m_exp;
    n_beat = m_beat;
    n_err  = m_err;
    n_flag = m_flag;
    if (m_acc) begin
      if (m_state == M_RUN && up_data == m_exp) n_exp = m_exp + DW'(1);
      else                                      n_exp = up_data + DW'(1);
      if (m_beat != '1) n_beat = m_beat + CW'(1);
      if (m_state == M_RUN && up_data != m_exp) begin
        n_flag = 1'b1;
        if (m_err != '1) n_err = m_err + CW'(1);
      end
    end
    if (clr) begin
      n_beat = '0;
      n_err  = '0;
      n_flag = 1'b0;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state <= M_IDLE;
      m_lfsr  <= 16'hACE1;
      m_ready <= 1'b0;
      m_exp   <= '0;
      m_beat  <= '0;
      m_err   <= '0;
      m_flag  <= 1'b0;
      sb.delete();
    end else begin
      m_exp   <= n_exp;
      m_beat  <= n_beat;
      m_err   <= n_err;
      m_flag  <= n_flag;
      m_ready <= en && (m_state != M_IDLE) && (m_lfsr[3:0] >= throttle);
      if (en) m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
      if (!en)                    m_state <= M_IDLE;
      else if (m_state == M_IDLE) m_state <= M_SYNC;
      else if (m_acc)             m_state <= M_RUN;
      if (m_acc) sb.push_back('{exp: n_exp, beat: n_beat, err: n_err, flag: n_flag});
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check_val("up_ready", up_ready, m_ready);
      if (sb.size() > 0) begin
        sb_item = sb.pop_front();
        check_val("sb_expected", expected, sb_item.exp);
        check_val("sb_beat_cnt", beat_cnt, sb_item.beat);
        check_val("sb_err_cnt",  err_cnt,  sb_item.err);
        check_val("sb_err_flag", err_flag, sb_item.flag);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic [DW-1:0] d);
    int unsigned n = 0;
    up_data  = d;
    up_valid = 1'b1;
    while (up_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (up_ready !== 1'b1) check_val("send_timeout", up_ready, 1);
    else @(negedge clk);
  endtask

  task automatic restart(input logic [3:0] thr);
    up_valid = 1'b0;
    en       = 1'b0;
    repeat (2) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr      = 1'b0;
    throttle = thr;
    en       = 1'b1;
  endtask

  int unsigned n_acc;
  logic        r_seen;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; throttle = 4'd0;
    up_data = '0; up_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_up_ready", up_ready, 0);
    check_val("rst_beat_cnt", beat_cnt, 0);
    check_val("rst_err_cnt",  err_cnt,  0);
    check_val("rst_err_flag", err_flag, 0);
    check_val("rst_expected", expected, 0);
    rst = 1'b0;

    // Basic stream 0..9 with throttle 0.
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    check_val("basic_ready_c1", up_ready, 0);
    @(negedge clk);
    check_val("basic_ready_c2", up_ready, 1);
    for (int i = 0; i < 10; i++) send(DW'(i));
    up_valid = 1'b0;
    check_val("basic_beat_cnt", beat_cnt, 10);
    check_val("basic_err_cnt",  err_cnt,  0);
    check_val("basic_err_flag", err_flag, 0);
    check_val("basic_expected", expected, 10);

    // Wrap 60..63,0,1.
    restart(4'd0);
    for (int i = 0; i < 6; i++) send(DW'(60 + i));
    up_valid = 1'b0;
    check_val("wrap_err_cnt",  err_cnt,  0);
    check_val("wrap_expected", expected, 2);
    check_val("wrap_beat_cnt", beat_cnt, 6);

    // en drop holds counters, clr clears, re-enable resyncs.
    restart(4'd0);
    for (int i = 0; i < 4; i++) send(DW'(i));
    up_valid = 1'b0;
    en       = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check_val("endrop_ready", up_ready, 0);
      check_val("endrop_beat",  beat_cnt, 4);
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check_val("clr_beat_cnt", beat_cnt, 0);
    check_val("clr_err_flag", err_flag, 0);
    en = 1'b1;
    send(DW'(50));
    send(DW'(51));
    up_valid = 1'b0;
    check_val("resync_err_cnt",  err_cnt,  0);
    check_val("resync_expected", expected, 52);
    check_val("resync_beat_cnt", beat_cnt, 2);

    // clr coinciding with an accepted beat.
    restart(4'd0);
    send(DW'(0));
    send(DW'(1));
    clr = 1'b1;
    send(DW'(2));
    clr      = 1'b0;
    up_valid = 1'b0;
    check_val("clracc_beat_cnt", beat_cnt, 0);
    check_val("clracc_expected", expected, 3);

    // Mismatch and resync: 5,6,9,10,11.
    restart(4'd0);
    send(DW'(5)); send(DW'(6)); send(DW'(9)); send(DW'(10)); send(DW'(11));
    up_valid = 1'b0;
    check_val("mm_err_cnt",  err_cnt,  1);
    check_val("mm_err_flag", err_flag, 1);
    check_val("mm_expected", expected, 12);
    check_val("mm_beat_cnt", beat_cnt, 5);

    // Async reset between edges while in RUN with err_flag set.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_val("arst_up_ready", up_ready, 0);
    check_val("arst_beat_cnt", beat_cnt, 0);
    check_val("arst_err_cnt",  err_cnt,  0);
    check_val("arst_err_flag", err_flag, 0);
    check_val("arst_expected", expected, 0);
    #1 rst = 1'b0;
    check_val("arst_lfsr", dut.u_lfsr.state, 32'hACE1);
    @(negedge clk);
    send(DW'(20));
    send(DW'(21));
    up_valid = 1'b0;
    check_val("arst_sync_err",  err_cnt,  0);
    check_val("arst_sync_exp",  expected, 22);
    check_val("arst_sync_beat", beat_cnt, 2);

    // Heavy throttle, source always valid.
    restart(4'd15);
    up_data  = '0;
    up_valid = 1'b1;
    n_acc    = 0;
    for (int i = 0; i < 1000; i++) begin
      r_seen = up_ready;
      @(negedge clk);
      if (r_seen) begin
        n_acc++;
        up_data = up_data + DW'(1);
      end
    end
    up_valid = 1'b0;
    @(negedge clk);
    check_val("thr_err_cnt",  err_cnt,  0);
    check_val("thr_beat_cnt", beat_cnt, n_acc);
    check_val("thr_range", (n_acc > 0 && n_acc < 250) ? 1 : 0, 1);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
